// File: rtl/riscv_check_pkg.sv
// Shared constants for the RISC-V store self-check monitor: FSM encoding,
// fail codes and the store counter width.
package riscv_check_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_MISMATCH = 3'd1;
  localparam logic [2:0] FC_TIMEOUT  = 3'd2;
  localparam logic [2:0] FC_EMPTY    = 3'd3;
  localparam logic [2:0] FC_OVERFLOW = 3'd4;

  localparam int STORE_CNT_W = 16;

  function automatic logic [STORE_CNT_W-1:0] sat_inc(input logic [STORE_CNT_W-1:0] v);
    return (v == {STORE_CNT_W{1'b1}}) ? v : v + {{(STORE_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/store_expect_table.sv
// Expected-store table: appends {addr, data} entries at exp_count, flags
// dropped writes as overflow, and reads the entry at the run's read pointer.
module store_expect_table #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [CW-1:0]   rd_ptr,
  output logic [CW-1:0]   exp_count,
  output logic            overflow,
  output logic [XLEN-1:0] rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              full_s;
  logic [2*XLEN-1:0] rd_entry_s;

  assign full_s = (count_q == CW'(DEPTH));

  // Table storage is never reset; only count_q decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en && !clear && !full_s) begin
      mem_q[count_q[IW-1:0]] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (wr_en) begin
      if (full_s) begin
        ovf_q <= 1'b1;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  always_comb begin
    rd_entry_s = '0;
    if (rd_ptr < CW'(DEPTH)) begin
      rd_entry_s = mem_q[rd_ptr[IW-1:0]];
    end else begin
      rd_entry_s = '0;
    end
  end

  assign rd_addr   = rd_entry_s[2*XLEN-1:XLEN];
  assign rd_data   = rd_entry_s[XLEN-1:0];
  assign exp_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/riscv_store_checker.sv
// In-order store checker: compares each core store against the expected
// table, skipping an ignore window, with timeout and sticky pass/fail status.
module riscv_store_checker
  import riscv_check_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 8,
  parameter int unsigned IGNORE_LO = 96,
  parameter int unsigned IGNORE_HI = 99,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         exp_wr_en,
  input  logic [XLEN-1:0]              exp_addr,
  input  logic [XLEN-1:0]              exp_data,
  input  logic                         mem_write,
  input  logic [XLEN-1:0]              data_adr,
  input  logic [XLEN-1:0]              write_data,
  output logic                         busy,
  output logic                         pass,
  output logic                         fail,
  output logic [2:0]                   fail_code,
  output logic [STORE_CNT_W-1:0]       store_count,
  output logic [$clog2(DEPTH+1)-1:0]   exp_count,
  output logic [XLEN-1:0]              err_addr,
  output logic [XLEN-1:0]              err_data
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] IGN_LO   = XLEN'(IGNORE_LO);
  localparam logic [XLEN-1:0] IGN_HI   = XLEN'(IGNORE_HI);
  localparam logic            IGN_EN   = (IGNORE_HI >= IGNORE_LO);

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [STORE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   busy_q, pass_q, pass_d, fail_q, fail_d;
  logic [2:0]             code_q, code_d;
  logic [XLEN-1:0]        err_addr_q, err_addr_d, err_data_q, err_data_d;

  logic [CW-1:0]   count_s;
  logic            overflow_s, tbl_wr_s, ignore_s, match_s;
  logic [XLEN-1:0] rd_addr_s, rd_data_s;

  assign tbl_wr_s = exp_wr_en && (state_q == ST_IDLE);

  store_expect_table #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) u_table (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_en     (tbl_wr_s),
    .wr_addr   (exp_addr),
    .wr_data   (exp_data),
    .rd_ptr    (rd_ptr_q),
    .exp_count (count_s),
    .overflow  (overflow_s),
    .rd_addr   (rd_addr_s),
    .rd_data   (rd_data_s)
  );

  assign ignore_s = IGN_EN && (data_adr >= IGN_LO) && (data_adr <= IGN_HI);
  assign match_s  = (data_adr == rd_addr_s) && (write_data == rd_data_s);

  // Next-state logic; a deciding store always outranks the timeout on the same edge.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    code_d     = code_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    if (clear) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      code_d  = FC_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
            code_d = FC_NONE;
            if (overflow_s) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = FC_OVERFLOW;
            end else if (count_s == '0) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = FC_EMPTY;
            end else begin
              state_d    = ST_RUN;
              rd_ptr_d   = '0;
              cnt_d      = '0;
              tmo_d      = '0;
              err_addr_d = '0;
              err_data_d = '0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          tmo_d = tmo_q + TW'(1);
          if (mem_write) begin
            cnt_d = sat_inc(cnt_q);
            if (ignore_s) begin
              rd_ptr_d = rd_ptr_q;
            end else if (match_s) begin
              rd_ptr_d = rd_ptr_q + CW'(1);
              if (rd_ptr_q == count_s - CW'(1)) begin
                state_d = ST_PASS;
                pass_d  = 1'b1;
              end else begin
                state_d = ST_RUN;
              end
            end else begin
              state_d    = ST_FAIL;
              fail_d     = 1'b1;
              code_d     = FC_MISMATCH;
              err_addr_d = data_adr;
              err_data_d = write_data;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if ((state_d == ST_RUN) && (tmo_q == TMO_LAST)) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = FC_TIMEOUT;
          end else begin
            tmo_d = tmo_d;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status and capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      code_q     <= FC_NONE;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d == ST_RUN);
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
    end
  end

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign store_count = cnt_q;
  assign exp_count   = count_s;
  assign err_addr    = err_addr_q;
  assign err_data    = err_data_q;

endmodule

// File: tb/tb_riscv_store_checker.sv
// Directed self-checking bench for riscv_store_checker (TIMEOUT shortened to 16).
module tb_riscv_store_checker;

  logic        clk = 1'b0;
  logic        reset, clear, start, exp_wr_en, mem_write;
  logic [31:0] exp_addr, exp_data, data_adr, write_data;
  logic        busy, pass, fail;
  logic [2:0]  fail_code;
  logic [15:0] store_count;
  logic [3:0]  exp_count;
  logic [31:0] err_addr, err_data;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_store_checker #(
    .XLEN(32), .DEPTH(8), .IGNORE_LO(96), .IGNORE_HI(99), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .exp_wr_en(exp_wr_en), .exp_addr(exp_addr), .exp_data(exp_data),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .store_count(store_count), .exp_count(exp_count),
    .err_addr(err_addr), .err_data(err_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    exp_wr_en = 1'b1; exp_addr = a; exp_data = d;
    tick();
    exp_wr_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; data_adr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0d want 0", busy); end
    n_cmp++; if (pass !== 1'b0 || fail !== 1'b0) begin n_bad++; $display("FAIL rst_pf got %0d%0d want 00", pass, fail); end
    n_cmp++; if (fail_code !== 3'd0) begin n_bad++; $display("FAIL rst_code got %0d want 0", fail_code); end
    n_cmp++; if (store_count !== 16'd0 || exp_count !== 4'd0) begin n_bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", store_count, exp_count); end
    n_cmp++; if (err_addr !== 32'd0 || err_data !== 32'd0) begin n_bad++; $display("FAIL rst_err got %0d/%0d want 0/0", err_addr, err_data); end
  endtask

  task automatic test_pass_ignore();
    do_clear();
    load(32'd100, 32'd25);
    n_cmp++; if (exp_count !== 4'd1) begin n_bad++; $display("FAIL t1_expcnt got %0d want 1", exp_count); end
    do_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %0d want 1", busy); end
    store(32'd96, 32'd7);
    n_cmp++; if (pass !== 1'b0 || busy !== 1'b1 || store_count !== 16'd1) begin n_bad++; $display("FAIL t1_ignored got p%0d b%0d c%0d want p0 b1 c1", pass, busy, store_count); end
    store(32'd100, 32'd25);
    n_cmp++; if (pass !== 1'b1 || fail !== 1'b0) begin n_bad++; $display("FAIL t1_pass got p%0d f%0d want p1 f0", pass, fail); end
    n_cmp++; if (fail_code !== 3'd0 || store_count !== 16'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL t1_status got code%0d c%0d b%0d want code0 c2 b0", fail_code, store_count, busy); end
  endtask

  task automatic test_mismatch();
    do_clear();
    load(32'd100, 32'd25);
    do_start();
    store(32'd104, 32'd7);
    n_cmp++; if (fail !== 1'b1 || fail_code !== 3'd1) begin n_bad++; $display("FAIL t2_fail got f%0d code%0d want f1 code1", fail, fail_code); end
    n_cmp++; if (err_addr !== 32'd104 || err_data !== 32'd7) begin n_bad++; $display("FAIL t2_err got %0d/%0d want 104/7", err_addr, err_data); end
    store(32'd100, 32'd25);
    n_cmp++; if (fail !== 1'b1 || pass !== 1'b0 || fail_code !== 3'd1 || store_count !== 16'd1) begin n_bad++; $display("FAIL t2_hold got f%0d p%0d code%0d c%0d want f1 p0 code1 c1", fail, pass, fail_code, store_count); end
    n_cmp++; if (err_addr !== 32'd104 || busy !== 1'b0) begin n_bad++; $display("FAIL t2_hold_err got %0d b%0d want 104 b0", err_addr, busy); end
  endtask

  task automatic test_timeout();
    int early;
    do_clear();
    load(32'd100, 32'd25);
    do_start();
    early = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (fail !== 1'b0 || busy !== 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL t3_early got %0d early cycles want 0", early); end
    tick();
    n_cmp++; if (fail !== 1'b1 || fail_code !== 3'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL t3_timeout got f%0d code%0d b%0d want f1 code2 b0", fail, fail_code, busy); end
    do_start();
    n_cmp++; if (fail !== 1'b0 || fail_code !== 3'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL t3_rearm got f%0d code%0d b%0d want f0 code0 b1", fail, fail_code, busy); end
    for (int i = 1; i < 16; i++) tick();
    store(32'd100, 32'd25);
    n_cmp++; if (pass !== 1'b1 || fail !== 1'b0 || fail_code !== 3'd0) begin n_bad++; $display("FAIL t3_match_on_tmo got p%0d f%0d code%0d want p1 f0 code0", pass, fail, fail_code); end
    do_start();
    for (int i = 1; i < 16; i++) tick();
    store(32'd104, 32'd7);
    n_cmp++; if (fail !== 1'b1 || fail_code !== 3'd1 || err_addr !== 32'd104) begin n_bad++; $display("FAIL t3_mism_on_tmo got f%0d code%0d a%0d want f1 code1 a104", fail, fail_code, err_addr); end
  endtask

  task automatic run_multi();
    store(32'd8, 32'd1);
    store(32'd97, 32'd0);
    store(32'd12, 32'd2);
    n_cmp++; if (pass !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL t4_mid got p%0d b%0d want p0 b1", pass, busy); end
    store(32'd100, 32'd25);
    n_cmp++; if (pass !== 1'b1 || store_count !== 16'd4 || exp_count !== 4'd3) begin n_bad++; $display("FAIL t4_pass got p%0d c%0d e%0d want p1 c4 e3", pass, store_count, exp_count); end
  endtask

  task automatic test_multi();
    do_clear();
    load(32'd8, 32'd1);
    load(32'd12, 32'd2);
    load(32'd100, 32'd25);
    n_cmp++; if (exp_count !== 4'd3) begin n_bad++; $display("FAIL t4_expcnt got %0d want 3", exp_count); end
    do_start();
    run_multi();
    do_start();
    n_cmp++; if (pass !== 1'b0 || store_count !== 16'd0) begin n_bad++; $display("FAIL t4_rearm got p%0d c%0d want p0 c0", pass, store_count); end
    run_multi();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 9; i++) load(32'(i * 4), 32'(i));
    n_cmp++; if (exp_count !== 4'd8) begin n_bad++; $display("FAIL t5_full got %0d want 8", exp_count); end
    do_start();
    n_cmp++; if (fail !== 1'b1 || fail_code !== 3'd4 || exp_count !== 4'd8) begin n_bad++; $display("FAIL t5_ovf got f%0d code%0d e%0d want f1 code4 e8", fail, fail_code, exp_count); end
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    n_cmp++; if (fail !== 1'b0 || busy !== 1'b0 || exp_count !== 4'd0 || fail_code !== 3'd0) begin n_bad++; $display("FAIL t5_clear got f%0d b%0d e%0d code%0d want 0 0 0 0", fail, busy, exp_count, fail_code); end
    do_start();
    n_cmp++; if (fail !== 1'b1 || fail_code !== 3'd3) begin n_bad++; $display("FAIL t5_empty got f%0d code%0d want f1 code3", fail, fail_code); end
  endtask

  task automatic test_async_reset();
    do_clear();
    load(32'd100, 32'd25);
    do_start();
    store(32'd97, 32'd0);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || fail_code !== 3'd0) begin n_bad++; $display("FAIL t6_status got b%0d p%0d f%0d code%0d want 0", busy, pass, fail, fail_code); end
    n_cmp++; if (store_count !== 16'd0 || exp_count !== 4'd0) begin n_bad++; $display("FAIL t6_counts got c%0d e%0d want 0/0", store_count, exp_count); end
    #1 reset = 1'b0;
    load(32'd100, 32'd25);
    n_cmp++; if (exp_count !== 4'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL t6_idle got e%0d b%0d want e1 b0", exp_count, busy); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; exp_wr_en = 1'b0; mem_write = 1'b0;
    exp_addr = '0; exp_data = '0; data_adr = '0; write_data = '0;
    #22 reset = 1'b0;
    test_reset();
    test_pass_ignore();
    test_mismatch();
    test_timeout();
    test_multi();
    test_overflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_store_checker.md
Name: riscv_store_checker

Overview:
- Synthesisable self-check monitor for the RISC-V cores. It watches the core's data-memory write bus (mem_write, data_adr, write_data).
- It compares each store, in order, against a runtime-loaded table of expected stores.
- Stores to a configurable ignore window are skipped; the run fails on timeout.
- It reports sticky pass/fail status with a fail code and the offending store, so every core test shares one checker instead of hard-coded bench logic.

Parameters:
- XLEN, 32, width of address and data buses.
- DEPTH, 8, maximum number of expected-store entries (>=1).
- IGNORE_LO, 96, lowest data address whose stores are ignored (inclusive).
- IGNORE_HI, 99, highest data address whose stores are ignored (inclusive); IGNORE_HI < IGNORE_LO disables the window.
- TIMEOUT, 4096, RUN cycles allowed before a timeout fail.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; empties the table, returns to IDLE.
- start  in  1  arms the check (from IDLE, PASS or FAIL).
- exp_wr_en  in  1  append one expected entry (IDLE only).
- exp_addr  in  XLEN  expected store address.
- exp_data  in  XLEN  expected store data.
- mem_write  in  1  core store strobe.
- data_adr  in  XLEN  core store address.
- write_data  in  XLEN  core store data.
- busy  out  1  state == RUN.
- pass  out  1  sticky success.
- fail  out  1  sticky failure.
- fail_code  out  3  0 none, 1 mismatch, 2 timeout, 3 empty table, 4 table overflow.
- store_count  out  16  stores seen in current run, ignored ones included; saturates at 65535.
- exp_count  out  $clog2(DEPTH+1)  entries loaded.
- err_addr  out  XLEN  address of first mismatching store.
- err_data  out  XLEN  data of first mismatching store.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-RUN):
  - State goes to IDLE.
  - All outputs 0; exp_count 0; overflow flag 0; read pointer 0; timeout counter 0.
  - Table contents need not be cleared.
- States are IDLE, RUN, PASS, FAIL. All outputs are registered, so status is visible the cycle after the deciding edge.
- IDLE:
  - exp_wr_en writes {exp_addr, exp_data} at index exp_count, then exp_count increments.
  - A write while exp_count == DEPTH is dropped and sets the sticky overflow flag.
- start in IDLE:
  - Overflow set -> FAIL, code 4.
  - Otherwise exp_count == 0 -> FAIL, code 3.
  - Otherwise -> RUN. This clears the read pointer, store_count, timeout counter, err_addr and err_data.
- RUN, on each edge with mem_write == 1:
  - store_count increments.
  - Address in [IGNORE_LO, IGNORE_HI] -> no comparison.
  - Otherwise, if both address and data equal entry[read pointer]: read pointer increments, and if this was entry exp_count-1 -> PASS.
  - Otherwise -> FAIL, code 1, with err_addr/err_data capturing the store.
- RUN timeout: the counter increments every RUN cycle. When it reaches TIMEOUT-1 without completion -> FAIL, code 2.
- Simultaneous events:
  - Final match and timeout on the same edge -> PASS.
  - Mismatch and timeout on the same edge -> code 1.
- exp_wr_en is ignored outside IDLE.
- mem_write is ignored outside RUN.
- PASS/FAIL:
  - Outputs hold.
  - start re-arms to RUN with the same table; pass/fail and fail_code clear on that edge.
- clear in any state -> IDLE: exp_count 0, overflow 0, pass/fail/code 0. clear takes priority over start and exp_wr_en on the same edge.
- Address and data compares are full XLEN-bit equality; no byte masks.

Decomposition:
- Shared package riscv_check_pkg:
  - state encoding (IDLE=0, RUN=1, PASS=2, FAIL=3);
  - fail-code constants FC_NONE..FC_OVERFLOW;
  - STORE_CNT_W = 16.
- Sub-module store_expect_table:
  - DEPTH x 2·XLEN register array;
  - write port with exp_count/overflow;
  - combinational read at the read pointer.
- The top level holds the FSM, timeout counter and capture registers.

Test Plan:
1. Load (100,25); start; store (96,7), then (100,25) -> pass=1 the next cycle, fail_code 0, store_count 2, busy 0.
2. Load (100,25); start; store (104,7) -> fail=1, fail_code 1, err_addr 104, err_data 7; a further store (100,25) changes nothing.
3. TIMEOUT=16; load (100,25); start with no stores -> fail=1 with code 2 exactly 16 cycles after start. Second run with the final match on the timeout edge -> pass=1.
4. Load (8,1), (12,2), (100,25); start; stores (8,1), (97,0), (12,2), (100,25) -> pass, store_count 4. start again with the same stores -> pass again, exp_count still 3.
5. DEPTH=8: nine exp_wr_en writes, then start -> fail code 4, exp_count 8. clear, then start -> fail code 3.
6. Assert reset mid-RUN, between clock edges -> busy/pass/fail/fail_code/store_count/exp_count are 0 before the next edge, and the state is IDLE after release.
